// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if: client request/response signals for two ports
// plus the ram8 pin bundle, shared by the arbiter and its environment.
interface ram8_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   logic                  req0;
   logic                  we0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] wdata0;
   logic                  gnt0;
   logic                  ack0;
   logic [DATA_WIDTH-1:0] rdata0;

   logic                  req1;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  gnt1;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata1;

   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_in;
   logic                  ram_load;
   logic [DATA_WIDTH-1:0] ram_out;

   // Clients and the ram8 side
   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      input  gnt0, ack0, rdata0,
      input  gnt1, ack1, rdata1,
      input  ram_address, ram_in, ram_load,
      output ram_out
   );

   // Arbiter side
   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      output gnt0, ack0, rdata0,
      output gnt1, ack1, rdata1,
      output ram_address, ram_in, ram_load,
      input  ram_out
   );
endinterface

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: serialises single-word transactions from two ports
// onto one ram8; IDLE -> ACCESS -> DONE, three cycles per transaction.
module ram8_arbiter #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 3,
   parameter int ROUND_ROBIN = 1
) (
   input logic          clk,
   input logic          reset,
   ram8_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t                state;
   logic                  owner;
   logic                  last_grant;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  load_q;
   logic                  gnt0_q;
   logic                  gnt1_q;
   logic                  ack0_q;
   logic                  ack1_q;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;

   logic                  win;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Pick the winning port and mux its request fields
   always_comb begin
      win = 1'b0;
      if (bus.req0 && bus.req1) begin
         win = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
      end else if (bus.req1) begin
         win = 1'b1;
      end
      w_we    = win ? bus.we1    : bus.we0;
      w_addr  = win ? bus.addr1  : bus.addr0;
      w_wdata = win ? bus.wdata1 : bus.wdata0;
   end

   // Transaction FSM with registered grant/ack/ram pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         load_q     <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  owner   <= win;
                  addr_q  <= w_addr;
                  wdata_q <= w_wdata;
                  we_q    <= w_we;
                  load_q  <= w_we;
                  gnt0_q  <= ~win;
                  gnt1_q  <= win;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               gnt0_q <= 1'b0;
               gnt1_q <= 1'b0;
               load_q <= 1'b0;
               if (!we_q) begin
                  if (owner) rdata1_q <= bus.ram_out;
                  else       rdata0_q <= bus.ram_out;
               end
               ack0_q     <= ~owner;
               ack1_q     <= owner;
               last_grant <= owner;
               state      <= DONE;
            end
            DONE: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0        = gnt0_q;
   assign bus.gnt1        = gnt1_q;
   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.rdata0      = rdata0_q;
   assign bus.rdata1      = rdata1_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_in      = wdata_q;
   assign bus.ram_load    = load_q;

endmodule
